// File: rtl/lock_pkg.sv
// Shared constants for the electronic lock and the code sender that drives it.
package lock_pkg;

    // Code sender FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRESS = 3'd1,
        ST_GAP   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } sender_state_e;

    // Meaning of one code bit: which button it presses
    localparam logic BTN_0 = 1'b0;
    localparam logic BTN_1 = 1'b1;

    // States of the lock itself
    typedef enum logic [1:0] {
        LK_LOCKED = 2'd0,
        LK_ENTRY  = 2'd1,
        LK_OPEN   = 2'd2
    } lock_state_e;

    // Width of a counter that must hold values 0..max_val, never narrower than one bit
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lock_code_sender.sv
// Sends a button-press code to an electronic lock, one press per bit (MSB first),
// spaced by GAP idle cycles, then waits up to TIMEOUT cycles for the lock to open.
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int CODE_LEN = 5,
    parameter int GAP      = 1,
    parameter int TIMEOUT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    input  logic                unlock,
    output logic                b0,
    output logic                b1,
    output logic                busy,
    output logic                done,
    output logic                pass
);

    localparam int IDX_W  = cnt_width(CODE_LEN - 1);
    localparam int GAP_W  = cnt_width((GAP > 0) ? (GAP - 1) : 0);
    localparam int WAIT_W = cnt_width(TIMEOUT - 1);

    sender_state_e       state_q;
    logic [CODE_LEN-1:0] shift_q;   // MSB is always the next bit to press
    logic [IDX_W-1:0]    idx_q;     // index of the press currently on the outputs
    logic [GAP_W-1:0]    gap_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                b0_q;
    logic                b1_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    // Sequencer: state, counters and all outputs are computed together so every
    // output is a flop that already reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            wait_q  <= '0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // First press goes out in the cycle right after acceptance
                        state_q <= ST_PRESS;
                        busy_q  <= 1'b1;
                        shift_q <= code << 1;
                        idx_q   <= '0;
                        gap_q   <= '0;
                        wait_q  <= '0;
                        pass_q  <= 1'b0;
                        b1_q    <= (code[CODE_LEN-1] == BTN_1);
                        b0_q    <= (code[CODE_LEN-1] == BTN_0);
                    end else begin
                        busy_q <= 1'b0;
                        b0_q   <= 1'b0;
                        b1_q   <= 1'b0;
                    end
                end
                ST_PRESS: begin
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        state_q <= ST_WAIT;
                        wait_q  <= '0;
                        b0_q    <= 1'b0;
                        b1_q    <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (GAP > 0) begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                            b0_q    <= 1'b0;
                            b1_q    <= 1'b0;
                        end else begin
                            // Back-to-back presses when no gap is configured
                            state_q <= ST_PRESS;
                            shift_q <= shift_q << 1;
                            b1_q    <= (shift_q[CODE_LEN-1] == BTN_1);
                            b0_q    <= (shift_q[CODE_LEN-1] == BTN_0);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        state_q <= ST_PRESS;
                        gap_q   <= '0;
                        shift_q <= shift_q << 1;
                        b1_q    <= (shift_q[CODE_LEN-1] == BTN_1);
                        b0_q    <= (shift_q[CODE_LEN-1] == BTN_0);
                    end else begin
                        gap_q <= gap_q + 1'b1;
                        b0_q  <= 1'b0;
                        b1_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    b0_q <= 1'b0;
                    b1_q <= 1'b0;
                    if (unlock) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    b0_q    <= 1'b0;
                    b1_q    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    shift_q <= '0;
                    idx_q   <= '0;
                    gap_q   <= '0;
                    wait_q  <= '0;
                    b0_q    <= 1'b0;
                    b1_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign b0   = b0_q;
    assign b1   = b1_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Scoreboard bench for lock_code_sender: one instance with GAP=1, one with GAP=0,
// each paired with a small behavioural lock that opens on the secret code.
module tb_lock_code_sender;

    localparam int         L      = 5;
    localparam int         TO     = 4;
    localparam logic [4:0] SECRET = 5'b01011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_a, unlock_a, b0_a, b1_a, busy_a, done_a, pass_a;
    logic         start_b, unlock_b, b0_b, b1_b, busy_b, done_b, pass_b;
    logic [L-1:0] code_a, code_b;

    lock_code_sender #(.CODE_LEN(L), .GAP(1), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .code(code_a), .unlock(unlock_a),
        .b0(b0_a), .b1(b1_a), .busy(busy_a), .done(done_a), .pass(pass_a)
    );

    lock_code_sender #(.CODE_LEN(L), .GAP(0), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .code(code_b), .unlock(unlock_b),
        .b0(b0_b), .b1(b1_b), .busy(busy_b), .done(done_b), .pass(pass_b)
    );

    // v = {busy, b0, b1, done, pass}; noise forces unlock high in that cycle; pulse re-raises start
    typedef struct packed {
        logic [4:0] v;
        logic       noise;
        logic       pulse;
    } exp_t;

    exp_t         q_a[$];
    exp_t         q_b[$];
    int           checks   = 0;
    int           failures = 0;
    logic         held_a, held_b, pdone_a, pdone_b;
    logic [L-1:0] hist_a, hist_b;
    int           cnt_a, cnt_b;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs for one transaction, cycle 1 = first cycle after start is sampled
    task automatic plan(input bit which, input logic [L-1:0] c, input int gap,
                        input bit noise, input bit pulses);
        int   last;
        int   dc;
        bit   p;
        logic pr;
        logic bv;
        exp_t e;
        last = 1 + (L - 1) * (gap + 1);
        p    = (c == SECRET);
        dc   = p ? last + 2 : last + TO + 1;
        for (int cy = 1; cy <= dc; cy++) begin
            pr = 1'b0;
            bv = 1'b0;
            for (int i = 0; i < L; i++) begin
                if (cy == 1 + i * (gap + 1)) begin
                    pr = 1'b1;
                    bv = c[L-1-i];
                end
            end
            e.v     = {1'b1, pr & ~bv, pr & bv, (cy == dc), (cy == dc) & p};
            e.noise = noise && (cy <= last);
            e.pulse = pulses && (cy == 2 || cy == 6);
            if (which) q_b.push_back(e);
            else       q_a.push_back(e);
        end
    endtask

    task automatic send(input bit which, input logic [L-1:0] c, input bit noise, input bit pulses);
        if (!which) begin
            start_a = 1'b1; code_a = c; hist_a = '0; cnt_a = 0;
            plan(1'b0, c, 1, noise, pulses);
        end else begin
            start_b = 1'b1; code_b = c; hist_b = '0; cnt_b = 0;
            plan(1'b1, c, 0, noise, pulses);
        end
    endtask

    task automatic step();
        exp_t ea;
        exp_t eb;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        code_a  = L'($urandom);
        code_b  = L'($urandom);
        if (q_a.size() > 0) ea = q_a.pop_front();
        else begin ea.v = {4'b0000, held_a}; ea.noise = 1'b0; ea.pulse = 1'b0; end
        if (q_b.size() > 0) eb = q_b.pop_front();
        else begin eb.v = {4'b0000, held_b}; eb.noise = 1'b0; eb.pulse = 1'b0; end
        held_a = ea.v[0];
        held_b = eb.v[0];
        check_val("a_out", {27'd0, busy_a, b0_a, b1_a, done_a, pass_a}, {27'd0, ea.v});
        check_val("b_out", {27'd0, busy_b, b0_b, b1_b, done_b, pass_b}, {27'd0, eb.v});
        check_val("a_excl", {31'd0, b0_a & b1_a}, 32'd0);
        check_val("b_excl", {31'd0, b0_b & b1_b}, 32'd0);
        check_val("a_done2", {31'd0, pdone_a & done_a}, 32'd0);
        check_val("b_done2", {31'd0, pdone_b & done_b}, 32'd0);
        pdone_a = done_a;
        pdone_b = done_b;
        // Registered lock: presses seen up to the previous cycle decide unlock now
        unlock_a = ((cnt_a >= L) && (hist_a == SECRET)) | ea.noise;
        unlock_b = ((cnt_b >= L) && (hist_b == SECRET)) | eb.noise;
        if (b0_a | b1_a) begin hist_a = {hist_a[L-2:0], b1_a}; if (cnt_a < L) cnt_a++; end
        if (b0_b | b1_b) begin hist_b = {hist_b[L-2:0], b1_b}; if (cnt_b < L) cnt_b++; end
        start_a = ea.pulse;
        start_b = eb.pulse;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && g < 200) begin
            step();
            g++;
        end
        step();
    endtask

    initial begin
        logic [L-1:0] ca;
        logic [L-1:0] cb;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; unlock_a = 1'b0; unlock_b = 1'b0;
        code_a = '0; code_b = '0;
        held_a = 1'b0; held_b = 1'b0; pdone_a = 1'b0; pdone_b = 1'b0;
        hist_a = '0; hist_b = '0; cnt_a = 0; cnt_b = 0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Correct code, GAP=1, extra start pulses and code changes mid-send
        send(1'b0, SECRET, 1'b0, 1'b1);
        drain();
        // Wrong code with unlock noise outside WAIT: times out
        send(1'b0, 5'b01010, 1'b1, 1'b0);
        drain();
        // GAP=0, correct code, back-to-back presses
        send(1'b1, SECRET, 1'b0, 1'b0);
        drain();
        // GAP=0, wrong code
        send(1'b1, 5'b11111, 1'b0, 1'b0);
        drain();

        // Reset in cycle 4 of a send, then a fresh start right after reset
        send(1'b0, SECRET, 1'b0, 1'b0);
        repeat (4) step();
        rst = 1'b1;
        q_a.delete();
        held_a = 1'b0; held_b = 1'b0;
        hist_a = '0; cnt_a = 0; unlock_a = 1'b0;
        step();
        rst = 1'b0;
        send(1'b0, SECRET, 1'b0, 1'b0);
        drain();

        // Both instances concurrently with assorted codes
        for (int k = 0; k < 4; k++) begin
            ca = (k == 0) ? SECRET : L'($urandom);
            cb = (k == 1) ? SECRET : L'($urandom);
            send(1'b0, ca, k[0], 1'b0);
            send(1'b1, cb, 1'b0, k[1]);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_code_sender.md
LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 SHALL have parameter CODE_LEN, default 5: number of button presses per code.
REQ-002 SHALL have parameter GAP, default 1: idle cycles between consecutive presses (0 allowed).
REQ-003 SHALL have parameter TIMEOUT, default 4: cycles to wait for unlock after the last press (≥1).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request to send code; sampled only in IDLE.
REQ-007 SHALL have port code, input, CODE_LEN: press sequence, MSB sent first; 0 = b0 press, 1 = b1 press.
REQ-008 SHALL have port unlock, input, 1: lock status fed back from the lock.
REQ-009 SHALL have port b0, output, 1: one-cycle "button 0" press pulse.
REQ-010 SHALL have port b1, output, 1: one-cycle "button 1" press pulse.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port pass, output, 1: result, valid while done=1 and held until next start accept.

Function
REQ-014 SHALL implement states IDLE, PRESS, GAP, WAIT, DONE; all outputs registered.
REQ-015 IDLE: start=1 at an edge SHALL latch code into a shift register, clear bit index and pass, and enter PRESS.
REQ-016 PRESS (one cycle): b0=1 if current bit is 0, else b1=1; b0 and b1 SHALL never both be 1 in any cycle.
REQ-017 PRESS exit: if bits remain, go to GAP when GAP>0, else directly to PRESS for the next bit; after the last bit, go to WAIT.
REQ-018 GAP SHALL last exactly GAP cycles with b0=b1=0, then return to PRESS.
REQ-019 WAIT SHALL sample unlock each cycle for up to TIMEOUT cycles: unlock=1 -> DONE with pass=1; counter expiry -> DONE with pass=0.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE is ignored.
REQ-021 start while busy=1 SHALL be ignored; code changes after acceptance SHALL have no effect.
REQ-022 Latency: with start sampled at edge 0, press i (i=0..CODE_LEN-1) SHALL appear in cycle 1+i*(GAP+1).
REQ-023 Counters SHALL be sized $clog2 of their maximum plus one and SHALL never wrap.
REQ-024 unlock=1 at any time outside WAIT SHALL have no effect.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, b0=b1=busy=done=pass=0, and zero counters and shift register, overriding all other inputs including start.
REQ-026 Reset mid-sequence SHALL abort the sequence with no further presses; start is accepted again at the first edge after rst deasserts.

Structure
REQ-027 State encoding constants SHALL live in a shared package lock_pkg, together with the lock's button and state constants.
REQ-028 SHALL be a single module with no sub-modules; the press shift register stays inline.

Verification
REQ-029 Paired with electronic_lock, code=5'b01011, GAP=1: start at edge 0 -> presses in cycles 1,3,5,7,9 (b0,b1,b0,b1,b1) -> done=1 and pass=1 in cycle 11.
REQ-030 code=5'b01010, TIMEOUT=4 -> unlock stays 0 -> done=1 and pass=0 in cycle 14.
REQ-031 GAP=0, code=5'b01011 -> presses in cycles 1–5 back-to-back -> pass=1, done in cycle 7.
REQ-032 start pulsed in cycles 2 and 6 during an active send -> no extra presses; exactly one done pulse.
REQ-033 rst in cycle 4 mid-send -> from cycle 5 all outputs 0, state IDLE; a new start then runs a full correct sequence.
REQ-034 All scenarios -> assertion that b0&b1 is never 1 and done is never high for 2 consecutive cycles.
